// File: rtl/gate_sweep_ctrl.sv
// Sweeps every input vector of a small combinational gate and records its truth table.
// Latency: each vector takes SETTLE+1 cycles; done pulses 2**N_IN*(SETTLE+1)+1 edges after start.
// Backpressure: none; start is honoured only in IDLE, and results hold until the next start or reset.
module gate_sweep_ctrl #(
  parameter int N_IN   = 2,
  parameter int SETTLE = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [(1<<N_IN)-1:0] expected,
  input  logic                 gate_out,
  output logic [N_IN-1:0]      gate_in,
  output logic                 busy,
  output logic                 done,
  output logic [(1<<N_IN)-1:0] truth_table,
  output logic [N_IN:0]        err_count,
  output logic [N_IN-1:0]      first_err_idx,
  output logic                 pass
);

  localparam int NV = 1 << N_IN;
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_SAMPLE,
    S_FINISH
  } state_t;

  state_t          state_q, state_d;
  logic [N_IN-1:0] idx_q, idx_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [NV-1:0]   exp_q, exp_d;
  logic [N_IN-1:0] gate_in_q, gate_in_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [NV-1:0]   tt_q, tt_d;
  logic [N_IN:0]   err_q, err_d;
  logic [N_IN-1:0] first_q, first_d;
  logic            pass_q, pass_d;

  // Next-state and next-output logic for the sweep sequencer.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    exp_d     = exp_q;
    gate_in_d = gate_in_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    tt_d      = tt_q;
    err_d     = err_q;
    first_d   = first_q;
    pass_d    = pass_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          // Snapshot the expected table so later port changes cannot skew the compare.
          exp_d     = expected;
          tt_d      = '0;
          err_d     = '0;
          first_d   = '0;
          pass_d    = 1'b0;
          gate_in_d = '0;
          idx_d     = '0;
          cnt_d     = '0;
          busy_d    = 1'b1;
          state_d   = S_WAIT;
        end
      end

      S_WAIT: begin
        if (cnt_q == CW'(SETTLE - 1)) begin
          state_d = S_SAMPLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_SAMPLE: begin
        tt_d[idx_q] = gate_out;
        if (gate_out != exp_q[idx_q]) begin
          err_d = err_q + (N_IN+1)'(1);
          if (err_q == '0) begin
            first_d = idx_q;
          end
        end
        // The last vector goes straight to FINISH so idx never wraps.
        if (idx_q == N_IN'(NV - 1)) begin
          state_d = S_FINISH;
        end else begin
          idx_d     = idx_q + N_IN'(1);
          gate_in_d = idx_q + N_IN'(1);
          cnt_d     = '0;
          state_d   = S_WAIT;
        end
      end

      S_FINISH: begin
        done_d    = 1'b1;
        busy_d    = 1'b0;
        pass_d    = (err_q == '0);
        gate_in_d = '0;
        state_d   = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; synchronous reset discards any partial sweep.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      cnt_q     <= '0;
      exp_q     <= '0;
      gate_in_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      tt_q      <= '0;
      err_q     <= '0;
      first_q   <= '0;
      pass_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      exp_q     <= exp_d;
      gate_in_q <= gate_in_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      tt_q      <= tt_d;
      err_q     <= err_d;
      first_q   <= first_d;
      pass_q    <= pass_d;
    end
  end

  assign gate_in       = gate_in_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign truth_table   = tt_q;
  assign err_count     = err_q;
  assign first_err_idx = first_q;
  assign pass          = pass_q;

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Directed bench for gate_sweep_ctrl: table of sweeps on a SETTLE=1 instance plus
// hand-written sequences for SETTLE=3, restart attempts and mid-sweep reset.
// Inputs are driven 1 time unit after posedge; outputs are sampled at the same point.
module tb_gate_sweep_ctrl;

  logic       clk;
  logic       rst;
  logic       start1, start3;
  logic [3:0] expected;
  int         gate_sel;  // 0 = AND, 1 = stuck at 0, 2 = OR

  logic [1:0] gi1, gi3;
  logic       go1, go3;
  logic       busy1, busy3, done1, done3, pass1, pass3;
  logic [3:0] tt1, tt3;
  logic [2:0] err1, err3;
  logic [1:0] first1, first3;

  int n_vec = 0;
  int n_err = 0;
  int tsel  = 0;  // which instance the sweep task observes

  logic [1:0] gi;
  logic       busy, done, pass;
  logic [3:0] tt;
  logic [2:0] err;
  logic [1:0] first;

  function automatic logic gate_fn(input int sel, input logic [1:0] v);
    case (sel)
      0:       return v[0] & v[1];
      1:       return 1'b0;
      default: return v[0] | v[1];
    endcase
  endfunction

  assign go1 = gate_fn(gate_sel, gi1);
  assign go3 = gate_fn(gate_sel, gi3);

  always_comb begin
    gi    = (tsel != 0) ? gi3    : gi1;
    busy  = (tsel != 0) ? busy3  : busy1;
    done  = (tsel != 0) ? done3  : done1;
    pass  = (tsel != 0) ? pass3  : pass1;
    tt    = (tsel != 0) ? tt3    : tt1;
    err   = (tsel != 0) ? err3   : err1;
    first = (tsel != 0) ? first3 : first1;
  end

  gate_sweep_ctrl #(.N_IN(2), .SETTLE(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .expected(expected), .gate_out(go1),
    .gate_in(gi1), .busy(busy1), .done(done1), .truth_table(tt1),
    .err_count(err1), .first_err_idx(first1), .pass(pass1)
  );

  gate_sweep_ctrl #(.N_IN(2), .SETTLE(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .expected(expected), .gate_out(go3),
    .gate_in(gi3), .busy(busy3), .done(done3), .truth_table(tt3),
    .err_count(err3), .first_err_idx(first3), .pass(pass3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    int         sel;
    logic [3:0] exp_in;
    logic [3:0] tt;
    logic [2:0] err;
    logic [1:0] first;
    logic       pass;
  } vec_t;

  // Runs one sweep on the selected instance, checking every cycle up to done and one cycle after.
  task automatic sweep(input int w, input vec_t v, input string nm,
                       input bit mid_change, input bit restart);
    int s;
    int last;
    int exp_gi;
    tsel     = w;
    gate_sel = v.sel;
    expected = v.exp_in;
    s        = (w != 0) ? 3 : 1;
    last     = 4 * (s + 1) + 1;
    if (w != 0) start3 = 1'b1; else start1 = 1'b1;
    tick();  // edge 0: start accepted
    start1 = 1'b0;
    start3 = 1'b0;
    for (int e = 0; e < last; e++) begin
      exp_gi = e / (s + 1);
      if (exp_gi > 3) exp_gi = 3;
      chk($sformatf("%s gate_in@%0d", nm, e), 32'(gi), 32'(exp_gi));
      chk($sformatf("%s busy@%0d", nm, e), 32'(busy), 32'd1);
      chk($sformatf("%s done@%0d", nm, e), 32'(done), 32'd0);
      if (e == 0) chk($sformatf("%s pass_clr", nm), 32'(pass), 32'd0);
      if (mid_change && e == 3) expected = 4'b0000;
      if (restart) begin
        if (e == 2) start1 = 1'b1;
        if (e == 3) start1 = 1'b0;
        if (e == last - 1) start1 = 1'b1;  // sampled while in FINISH
      end
      tick();
    end
    start1 = 1'b0;
    chk($sformatf("%s done_edge", nm), 32'(done), 32'd1);
    chk($sformatf("%s busy_at_done", nm), 32'(busy), 32'd0);
    chk($sformatf("%s gate_in_at_done", nm), 32'(gi), 32'd0);
    chk($sformatf("%s truth_table", nm), 32'(tt), 32'(v.tt));
    chk($sformatf("%s err_count", nm), 32'(err), 32'(v.err));
    chk($sformatf("%s first_err_idx", nm), 32'(first), 32'(v.first));
    chk($sformatf("%s pass", nm), 32'(pass), 32'(v.pass));
    tick();
    chk($sformatf("%s done_one_cycle", nm), 32'(done), 32'd0);
    chk($sformatf("%s busy_after", nm), 32'(busy), 32'd0);
    chk($sformatf("%s tt_held", nm), 32'(tt), 32'(v.tt));
    chk($sformatf("%s err_held", nm), 32'(err), 32'(v.err));
    chk($sformatf("%s pass_held", nm), 32'(pass), 32'(v.pass));
    tick();
    chk($sformatf("%s no_restart", nm), 32'(busy), 32'd0);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, " gate_in"}, 32'(gi), 32'd0);
    chk({nm, " busy"}, 32'(busy), 32'd0);
    chk({nm, " done"}, 32'(done), 32'd0);
    chk({nm, " truth_table"}, 32'(tt), 32'd0);
    chk({nm, " err_count"}, 32'(err), 32'd0);
    chk({nm, " first_err_idx"}, 32'(first), 32'd0);
    chk({nm, " pass"}, 32'(pass), 32'd0);
  endtask

  vec_t tbl[5];
  vec_t vx;

  initial begin
    // sel, expected, truth_table, err_count, first_err_idx, pass
    tbl[0] = '{0, 4'b1000, 4'b1000, 3'd0, 2'd0, 1'b1};  // correct AND
    tbl[1] = '{1, 4'b1000, 4'b0000, 3'd1, 2'd3, 1'b0};  // stuck at 0
    tbl[2] = '{2, 4'b1000, 4'b1110, 3'd2, 2'd1, 1'b0};  // OR instead of AND
    tbl[3] = '{0, 4'b0110, 4'b1000, 3'd3, 2'd1, 1'b0};  // three mismatches
    tbl[4] = '{0, 4'b0111, 4'b1000, 3'd4, 2'd0, 1'b0};  // every vector wrong

    rst      = 1'b1;
    start1   = 1'b0;
    start3   = 1'b0;
    expected = 4'b0000;
    gate_sel = 0;
    tick();
    tick();
    tsel = 0;
    #1;
    chk_all_zero("reset dut1");
    tsel = 1;
    #1;
    chk_all_zero("reset dut3");
    rst = 1'b0;
    tick();

    for (int i = 0; i < 5; i++) begin
      sweep(0, tbl[i], $sformatf("vec%0d", i), 1'b0, 1'b0);
    end

    // SETTLE=3 with expected changed mid-sweep: latched table still applies.
    sweep(1, tbl[0], "settle3", 1'b1, 1'b0);

    // start pulsed while busy and during FINISH: single sweep, unchanged results.
    sweep(0, tbl[2], "restart", 1'b0, 1'b1);

    // Reset during the WAIT of vector 2 with partial results present.
    tsel     = 0;
    gate_sel = 2;
    expected = 4'b1000;
    start1   = 1'b1;
    tick();  // edge 0
    start1 = 1'b0;
    repeat (4) tick();  // edge 4: WAIT for vector 2
    chk("midrst pre gate_in", 32'(gi), 32'd2);
    chk("midrst pre err", 32'(err), 32'd1);
    rst = 1'b1;
    tick();
    chk_all_zero("midrst");
    rst = 1'b0;
    tick();
    chk("midrst idle busy", 32'(busy), 32'd0);
    chk("midrst idle gate_in", 32'(gi), 32'd0);
    vx = tbl[0];
    sweep(0, vx, "after_rst", 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/gate_sweep_ctrl.md
Name: gate_sweep_ctrl

Overview:
Sequencer that exhaustively exercises one small combinational gate under test (e.g. and_gate). It drives every input combination in ascending order and waits a programmable settle time before sampling the gate output. It packs the samples into a truth-table register and compares them against an expected table latched at start. It is the hardware counterpart of the bench sweep loop and sits between a result/scoreboard collector and the gate instance.

Parameters:
N_IN, 2, number of gate inputs; sweep covers 2**N_IN vectors
SETTLE, 1, cycles gate_in is held stable before sampling; legal range >=1

Ports:
clk  input  1  clock, all state updates on posedge
rst  input  1  synchronous active-high reset
start  input  1  begin sweep; accepted only in IDLE
expected  input  2**N_IN  expected output per vector; bit k = expected result for gate_in==k
gate_out  input  1  output of gate under test
gate_in  output  N_IN  vector driven to gate under test
busy  output  1  high from the cycle after start acceptance until done
done  output  1  one-cycle pulse when results are valid
truth_table  output  2**N_IN  bit k = gate_out sampled for vector k
err_count  output  N_IN+1  number of vectors where gate_out != expected bit
first_err_idx  output  N_IN  lowest vector index that mismatched; 0 if none
pass  output  1  err_count==0, valid from done, held until next start

Behaviour:
- Reset (sync, rst=1 at posedge): state=IDLE. gate_in, busy, done, truth_table, err_count, first_err_idx and pass all go to 0. Reset wins over every other event, including mid-sweep. No partial results survive.
- All outputs are registered.
- States: IDLE, WAIT, SAMPLE, FINISH.
- IDLE, start=1:
  - latch expected into an internal register; later changes to the expected port are ignored.
  - clear truth_table, err_count, first_err_idx and pass.
  - set gate_in=0, idx=0, settle cnt=0, busy=1.
  - go to WAIT.
- WAIT: cnt increments each cycle. When cnt==SETTLE-1, go to SAMPLE. gate_in is therefore stable for SETTLE cycles before sampling.
- SAMPLE:
  - write gate_out into truth_table[idx].
  - on a mismatch with expected_q[idx], increment err_count. If this is the first mismatch, also set first_err_idx=idx.
  - if idx==2**N_IN-1, go to FINISH, otherwise idx++, gate_in=idx+1, cnt=0, go to WAIT.
- FINISH: for one cycle done=1, busy=0, pass=(err_count==0), gate_in=0. Go to IDLE.
- Timing: each vector takes SETTLE+1 cycles. done is first seen high exactly 2**N_IN*(SETTLE+1)+1 posedges after the posedge that sampled start. For N_IN=2, SETTLE=1 that is edge 9.
- start is ignored in WAIT, SAMPLE and FINISH. There is no queuing and no restart.
- truth_table, err_count, first_err_idx and pass hold their values after done until the next accepted start or reset.
- Width rule: err_count max is 2**N_IN, which fits in N_IN+1 bits; no saturation logic is needed.
- idx never wraps. The terminal compare is against 2**N_IN-1, and the increment is not performed on the last vector.

Test Plan:
- N_IN=2, SETTLE=1, correct AND gate (gate_in[0]=a, gate_in[1]=b), expected=4'b1000, start pulse → gate_in sequence 0,1,2,3; done is one cycle long at edge 9; truth_table=1000, err_count=0, pass=1, first_err_idx=0.
- Gate output stuck at 0, expected=1000 → truth_table=0000, err_count=1, first_err_idx=3, pass=0.
- OR gate in place of AND, expected=1000 → truth_table=1110, err_count=2, first_err_idx=1, pass=0.
- SETTLE=3 → each gate_in value is held 4 cycles and done rises at edge 17. expected changes mid-sweep to 0000 → results still use the latched 1000.
- start re-pulsed while busy, and again in the FINISH cycle → no restart, single done pulse, results unchanged.
- rst asserted during the vector-2 WAIT state → next cycle all outputs are 0 and state is IDLE. A following start runs a full clean sweep with correct results.
